// File: rtl/dcache_refill.sv
// dcache_refill: moves one cache line between the data cache and a byte-wide
// RAM. A fill reads BLOCK_SIZE bytes, one per cycle. The RAM returns each byte
// one cycle after its address, so the last byte arrives one cycle after the
// last address. A write-back writes the latched line out one byte per cycle.
// Every transfer ends with one DONE cycle. DONE gives the cache time to update
// its tag and dirty state before the next miss is accepted.
// Optional build macro DCACHE_REFILL_STATS_EN adds the fill and write-back
// event counters fillCount and writeBackCount.
module dcache_refill #(
    parameter int BLOCK_WIDTH = 4,
    parameter int BLOCK_SIZE  = 2**BLOCK_WIDTH
) (
    input  logic                    clkIn,
    input  logic                    resetIn,
    input  logic                    clearIn,
    input  logic                    miss,
    input  logic [31:BLOCK_WIDTH]   missAddr,
    input  logic                    readWriteIn,
    input  logic [BLOCK_SIZE*8-1:0] writeBackIn,
    output logic                    memDataValid,
    output logic [31:BLOCK_WIDTH]   memAddr,
    output logic [BLOCK_SIZE*8-1:0] memDataOut,
    output logic                    acceptWrite,
    input  logic [7:0]              ramDataIn,
    output logic [7:0]              ramDataOut,
    output logic [31:0]             ramAddr,
    output logic                    ramWrite
`ifdef DCACHE_REFILL_STATS_EN
    ,
    output logic [31:0]             fillCount,
    output logic [31:0]             writeBackCount
`endif
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} stateT;

    localparam logic [4:0] LAST = 5'(BLOCK_SIZE - 1);
    localparam logic [4:0] FULL = 5'(BLOCK_SIZE);

    stateT                        state, stateNext;
    logic [4:0]                   cnt;
    logic [BLOCK_SIZE*8-1:0]      wbBuf;
    // Only bytes 0..BLOCK_SIZE-2 are buffered.
    // The top byte goes straight from ramDataIn into memDataOut.
    logic [(BLOCK_SIZE-1)*8-1:0]  lineBuf;

    // State register; reset takes effect at once, which abandons any transfer.
    always_ff @(posedge clkIn or posedge resetIn) begin
        if (resetIn) state <= IDLE;
        else         state <= stateNext;
    end

    // Next state and the combinational RAM port, which is idle outside READ/WRITE.
    always_comb begin
        stateNext  = state;
        ramWrite   = 1'b0;
        ramAddr    = '0;
        ramDataOut = '0;
        case (state)
            IDLE: if (miss) stateNext = readWriteIn ? READ : WRITE;
            READ: begin
                if (cnt < FULL) ramAddr = {memAddr, cnt[BLOCK_WIDTH-1:0]};
                if (clearIn)          stateNext = IDLE;
                else if (cnt == FULL) stateNext = DONE;
            end
            WRITE: begin
                ramWrite   = 1'b1;
                ramAddr    = {memAddr, cnt[BLOCK_WIDTH-1:0]};
                ramDataOut = wbBuf[{cnt[BLOCK_WIDTH-1:0], 3'b000} +: 8];
                if (cnt == LAST) stateNext = DONE;
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Datapath: latch the request, count bytes, assemble the line, emit completion pulses.
    always_ff @(posedge clkIn or posedge resetIn) begin
        if (resetIn) begin
            cnt          <= '0;
            wbBuf        <= '0;
            lineBuf      <= '0;
            memAddr      <= '0;
            memDataOut   <= '0;
            memDataValid <= 1'b0;
            acceptWrite  <= 1'b0;
        end else begin
            memDataValid <= 1'b0;
            acceptWrite  <= 1'b0;
            case (state)
                IDLE: if (miss) begin
                    memAddr <= missAddr;
                    wbBuf   <= writeBackIn;
                    cnt     <= '0;
                end
                // A flush freezes the fill; IDLE discards the partial line.
                READ: if (!clearIn) begin
                    if (cnt < FULL) cnt <= cnt + 5'd1;
                    if (cnt != 5'd0 && cnt < FULL)
                        lineBuf[{BLOCK_WIDTH'(cnt[BLOCK_WIDTH-1:0] - 1'b1), 3'b000} +: 8] <= ramDataIn;
                    if (cnt == FULL) begin
                        memDataOut   <= {ramDataIn, lineBuf};
                        memDataValid <= 1'b1;
                    end
                end
                WRITE: begin
                    cnt <= cnt + 5'd1;
                    if (cnt == LAST) acceptWrite <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef DCACHE_REFILL_STATS_EN
    // Event counters. They wrap naturally at 2^32.
    always_ff @(posedge clkIn or posedge resetIn) begin
        if (resetIn) begin
            fillCount      <= '0;
            writeBackCount <= '0;
        end else begin
            if (memDataValid) fillCount      <= fillCount + 32'd1;
            if (acceptWrite)  writeBackCount <= writeBackCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_refill.sv
// Testbench for dcache_refill.
// A table of directed transfers runs first, then randomized transfers.
// Expected behaviour for every cycle comes from a transaction-level model:
// the cycle index after acceptance, the line address and the RAM contents.
module tb_dcache_refill;
    localparam int BW = 4;
    localparam int BS = 16;

    logic          clkIn = 1'b0;
    logic          resetIn, clearIn, miss, readWriteIn;
    logic [31:BW]  missAddr;
    logic [127:0]  writeBackIn;
    logic          memDataValid, acceptWrite, ramWrite;
    logic [31:BW]  memAddr;
    logic [127:0]  memDataOut;
    logic [7:0]    ramDataIn, ramDataOut;
    logic [31:0]   ramAddr;
`ifdef DCACHE_REFILL_STATS_EN
    logic [31:0]   fillCount, writeBackCount;
`endif

    dcache_refill #(.BLOCK_WIDTH(BW)) dut (
        .clkIn(clkIn), .resetIn(resetIn), .clearIn(clearIn), .miss(miss),
        .missAddr(missAddr), .readWriteIn(readWriteIn), .writeBackIn(writeBackIn),
        .memDataValid(memDataValid), .memAddr(memAddr), .memDataOut(memDataOut),
        .acceptWrite(acceptWrite), .ramDataIn(ramDataIn), .ramDataOut(ramDataOut),
        .ramAddr(ramAddr), .ramWrite(ramWrite)
`ifdef DCACHE_REFILL_STATS_EN
        , .fillCount(fillCount), .writeBackCount(writeBackCount)
`endif
    );

    always #5 clkIn = ~clkIn;

    // RAM model: the byte for an address is returned one cycle later.
    logic [7:0] mem [0:255];
    always @(posedge clkIn) ramDataIn <= mem[ramAddr[7:0]];

    int checks = 0;
    int failures = 0;
    int expFills = 0;
    int expWbs = 0;

    typedef struct {
        bit          rw;
        logic [27:0] addr;
        logic [127:0] wb;
        int          clearAt;   // cycle of a transfer with clearIn=1 (0 = none)
        int          expPulses; // completion pulses expected
    } vecT;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Run one transfer.
    // Cycle k is the k-th cycle after the accepting edge.
    // Outputs are sampled at the negedge, then inputs for that cycle are driven.
    task automatic runTxn(input vecT v);
        logic [127:0] line;
        bit aborted;
        int pulses;
        pulses = 0;
        aborted = v.rw && v.clearAt > 0;
        for (int i = 0; i < BS; i++) line[i*8 +: 8] = mem[{v.addr[3:0], 4'(i)}];
        @(negedge clkIn);
        miss = 1'b1; readWriteIn = v.rw; missAddr = v.addr; writeBackIn = v.wb; clearIn = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clkIn);
            if (memDataValid || acceptWrite) pulses++;
            chk("excl", {127'd0, memDataValid & acceptWrite}, 128'd0);
            if (v.rw) begin
                chk("rdAccept", {127'd0, acceptWrite}, 128'd0);
                if (aborted && k > v.clearAt) begin
                    chk("flushAddr", ramAddr, 128'd0);
                    chk("flushValid", {127'd0, memDataValid}, 128'd0);
                end else if (k <= 16) begin
                    chk("rdAddr", ramAddr, {96'd0, v.addr, 4'(k-1)});
                    chk("rdWrite", {127'd0, ramWrite}, 128'd0);
                    chk("rdValid", {127'd0, memDataValid}, 128'd0);
                end else if (k == 17) begin
                    chk("rdValid17", {127'd0, memDataValid}, 128'd0);
                    chk("rdWrite17", {127'd0, ramWrite}, 128'd0);
                end else if (k == 18) begin
                    chk("fillValid", {127'd0, memDataValid}, 128'd1);
                    chk("fillLine", memDataOut, line);
                    chk("fillMemAddr", {100'd0, memAddr}, {100'd0, v.addr});
                    chk("doneRamAddr", ramAddr, 128'd0);
                end else begin
                    chk("postValid", {127'd0, memDataValid}, 128'd0);
                    chk("postRamAddr", ramAddr, 128'd0);
                end
            end else begin
                chk("wrValid", {127'd0, memDataValid}, 128'd0);
                if (k <= 16) begin
                    chk("wrWrite", {127'd0, ramWrite}, 128'd1);
                    chk("wrAddr", ramAddr, {96'd0, v.addr, 4'(k-1)});
                    chk("wrData", {120'd0, ramDataOut}, {120'd0, v.wb[(k-1)*8 +: 8]});
                    chk("wrAccept", {127'd0, acceptWrite}, 128'd0);
                end else if (k == 17) begin
                    chk("acceptWrite", {127'd0, acceptWrite}, 128'd1);
                    chk("wbMemAddr", {100'd0, memAddr}, {100'd0, v.addr});
                    chk("doneWrite", {127'd0, ramWrite}, 128'd0);
                    chk("doneAddr", ramAddr, 128'd0);
                end else begin
                    chk("postAccept", {127'd0, acceptWrite}, 128'd0);
                    chk("postWrite", {127'd0, ramWrite}, 128'd0);
                end
            end
            clearIn = (k == v.clearAt);
            // Scramble request inputs while the transfer owns the FSM.
            if (k <= 15 && !(aborted && k > v.clearAt)) begin
                miss = 1'($urandom); readWriteIn = 1'($urandom); missAddr = 28'($urandom);
                writeBackIn = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                miss = 1'b0;
            end
        end
        clearIn = 1'b0; miss = 1'b0;
        chk("pulseCount", 128'(pulses), 128'(v.expPulses));
        if (v.rw && !aborted) expFills++;
        if (!v.rw) expWbs++;
    endtask

    vecT vecs[6];
    vecT rv;

    initial begin
        vecs[0] = '{1'b1, 28'h0000100, 128'd0, 0, 1};
        vecs[1] = '{1'b0, 28'h0000200, 128'hFFEEDDCCBBAA99887766554433221100, 0, 1};
        vecs[2] = '{1'b1, 28'h0000300, 128'd0, 5, 0};
        vecs[3] = '{1'b0, 28'h0000400, 128'h0123456789ABCDEF_FEDCBA9876543210, 5, 1};
        vecs[4] = '{1'b1, 28'hABCDEF1, 128'd0, 17, 0};
        vecs[5] = '{1'b1, 28'h1234567, 128'd0, 1, 0};
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);

        resetIn = 1'b1; clearIn = 1'b0; miss = 1'b0; readWriteIn = 1'b0;
        missAddr = '0; writeBackIn = '0;
        #12;
        chk("rstRamWrite", {127'd0, ramWrite}, 128'd0);
        chk("rstRamAddr", ramAddr, 128'd0);
        chk("rstMemAddr", {100'd0, memAddr}, 128'd0);
        chk("rstMemData", memDataOut, 128'd0);
        chk("rstPulses", {126'd0, memDataValid, acceptWrite}, 128'd0);
        @(negedge clkIn); resetIn = 1'b0;

        // Directed table
        for (int i = 0; i < 6; i++) runTxn(vecs[i]);
        chk("req033Line", memDataOut, 128'h0F0E0D0C0B0A09080706050403020100);

        // Back-to-back fills with miss held high
        @(negedge clkIn);
        miss = 1'b1; readWriteIn = 1'b1; missAddr = 28'h0000500;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clkIn);
            if (k == 1) chk("b2bFirstAddr", ramAddr, 128'h5000);
            if (k == 18) begin
                chk("b2bValid", {127'd0, memDataValid}, 128'd1);
                chk("b2bMemAddr", {100'd0, memAddr}, 128'h0000500);
                chk("b2bDoneWrite", {127'd0, ramWrite}, 128'd0);
                chk("b2bDoneAddr", ramAddr, 128'd0);
            end
            if (k == 19) chk("b2bIdleAddr", ramAddr, 128'd0);
            if (k == 20) chk("b2bSecondAddr", ramAddr, 128'h6000);
            missAddr = 28'h0000600;
            if (k == 20) miss = 1'b0;
        end
        repeat (20) @(negedge clkIn);
        chk("b2bSecondLine", memDataOut, 128'h0F0E0D0C0B0A09080706050403020100);
        expFills += 2;

        // Asynchronous reset in the middle of a write-back
        @(negedge clkIn);
        miss = 1'b1; readWriteIn = 1'b0; missAddr = 28'h0000700; writeBackIn = {4{32'hA5A5_5A5A}};
        for (int k = 1; k <= 8; k++) begin
            @(negedge clkIn);
            miss = 1'b0;
        end
        chk("midWrite", {127'd0, ramWrite}, 128'd1);
        chk("midAddr", ramAddr, 128'h7007);
        #1 resetIn = 1'b1;
        #1;
        chk("asyncRamWrite", {127'd0, ramWrite}, 128'd0);
        chk("asyncRamAddr", ramAddr, 128'd0);
        chk("asyncMemAddr", {100'd0, memAddr}, 128'd0);
        @(negedge clkIn); resetIn = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clkIn);
            chk("rstNoAccept", {127'd0, acceptWrite}, 128'd0);
            chk("rstIdle", {127'd0, ramWrite}, 128'd0);
        end
        expFills = 0; expWbs = 0;   // the counters were reset too

        // Randomized transfers
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        for (int n = 0; n < 40; n++) begin
            rv.rw = 1'($urandom);
            rv.addr = 28'($urandom);
            rv.wb = {$urandom, $urandom, $urandom, $urandom};
            rv.clearAt = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 17) : 0;
            rv.expPulses = (rv.rw && rv.clearAt > 0) ? 0 : 1;
            runTxn(rv);
        end

`ifdef DCACHE_REFILL_STATS_EN
        chk("fillCount", {96'd0, fillCount}, 128'(expFills));
        chk("writeBackCount", {96'd0, writeBackCount}, 128'(expWbs));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
